// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset pulses, waits for a filtered lock with
// timeout and bounded retries, and produces a clean system reset. Runs on refclk.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 100000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned MAX_RETRY        = 7,
  parameter int unsigned CNT_W            = 20
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q, sys_rst_d;
  logic             pll_ready_q, pll_ready_d;
  logic             lock_fail_q, lock_fail_d;

  logic             restart;
  logic [3:0]       retry_inc;
  logic [7:0]       relock_inc;

  assign retry_inc  = retry_q + 4'd1;
  assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  // extlock is asynchronous to refclk; only the second synchronizer stage is trusted.
  assign sync1_d  = extlock;
  assign lock_s_d = sync1_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    restart  = 1'b0;

    if (force_relock) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
      restart = 1'b1;
      if ((state_q == S_RUN) && !lock_s_q) relock_d = relock_inc;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_STABLE: begin
          // Any dropout restarts the timeout but is not counted as a retry.
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            relock_d = relock_inc;
            state_d  = S_RESET_PLL;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET_PLL;
        end
      endcase
    end
  end

  // The shared counter measures time spent in the current state only.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == S_RESET_PLL) || (state_q == S_WAIT_LOCK) ||
                 (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_d   = (state_d != S_RUN);
    pll_ready_d = (state_d == S_RUN);
    lock_fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk or posedge reset) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      pll_ready_q <= pll_ready_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign sys_rst    = sys_rst_q;
  assign pll_ready  = pll_ready_q;
  assign lock_fail  = lock_fail_q;
  assign retry_cnt  = retry_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: vector table, directed corner
// sequences, and randomized stimulus against a deadline-based reference model.
module tb_pll_lock_supervisor;

  localparam int RST  = 4;
  localparam int TO   = 50;
  localparam int STB  = 8;
  localparam int MAXR = 3;

  logic       refclk = 1'b0;
  logic       reset = 1'b1;
  logic       extlock = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_reset, sys_rst, pll_ready, lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC(RST), .LOCK_TIMEOUT_CYC(TO), .LOCK_STABLE_CYC(STB),
    .MAX_RETRY(MAXR), .CNT_W(20)
  ) dut (
    .refclk(refclk), .reset(reset), .extlock(extlock), .force_relock(force_relock),
    .pll_reset(pll_reset), .sys_rst(sys_rst), .pll_ready(pll_ready),
    .lock_fail(lock_fail), .retry_cnt(retry_cnt), .relock_cnt(relock_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  function automatic logic [15:0] outs();
    return {pll_reset, sys_rst, pll_ready, lock_fail, retry_cnt, relock_cnt};
  endfunction

  // Reference model: phases with entry timestamps; a phase of length N ends N edges after entry.
  localparam int P_PULSE = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  int m_ph = P_PULSE, m_start = 0, m_cyc = 0, m_retry = 0, m_relock = 0;
  bit m_lk[$] = '{1'b0, 1'b0};

  task automatic m_reset();
    m_ph = P_PULSE; m_start = 0; m_cyc = 0; m_retry = 0; m_relock = 0;
    m_lk = '{1'b0, 1'b0};
  endtask

  task automatic m_enter(input int ph);
    m_ph = ph;
    m_start = m_cyc;
  endtask

  task automatic m_edge(input bit ext, input bit fr);
    bit lock;
    int age;
    lock = m_lk.pop_front();
    m_lk.push_back(ext);
    m_cyc++;
    age = m_cyc - m_start;
    if (fr) begin
      if (m_ph == P_RUN && !lock) m_relock = (m_relock < 255) ? m_relock + 1 : 255;
      m_retry = 0;
      m_enter(P_PULSE);
    end else begin
      case (m_ph)
        P_PULSE: if (age == RST) m_enter(P_WAIT);
        P_WAIT: begin
          if (lock) m_enter(P_STAB);
          else if (age == TO) begin
            m_retry++;
            m_enter((m_retry == MAXR) ? P_FAIL : P_PULSE);
          end
        end
        P_STAB: begin
          if (!lock) m_enter(P_WAIT);
          else if (age == STB) begin m_retry = 0; m_enter(P_RUN); end
        end
        P_RUN: begin
          if (!lock) begin
            m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_enter(P_PULSE);
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] m_outs();
    return {(m_ph == P_PULSE || m_ph == P_FAIL), (m_ph != P_RUN), (m_ph == P_RUN),
            (m_ph == P_FAIL), 4'(m_retry), 8'(m_relock)};
  endfunction

  always @(posedge refclk or posedge reset) begin
    if (reset) m_reset();
    else m_edge(extlock, force_relock);
  end

  typedef struct {
    bit          ext;
    bit          fr;
    logic [15:0] exp;
  } vec_t;

  function automatic vec_t mk(bit ext, bit fr, bit pr, bit sr, bit rdy);
    vec_t v;
    v.ext = ext;
    v.fr  = fr;
    v.exp = {pr, sr, rdy, 1'b0, 4'd0, 8'd0};
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; extlock = 1'b0; force_relock = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   n, len, bad, first, fall, tmo;
    int   runs[$];
    logic lvl;
    int   seg;
    bit   slvl;

    // Clean lock, force_relock in RUN, and force_relock restarting the pulse.
    for (int i = 0; i < 3; i++)   vecs.push_back(mk(0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0));
    for (int i = 4; i < 14; i++)  vecs.push_back(mk(1, 0, 0, 1, 0));
    for (int i = 14; i < 16; i++) vecs.push_back(mk(1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0));
    for (int i = 19; i < 22; i++) vecs.push_back(mk(1, 0, 1, 1, 0));
    for (int i = 22; i < 24; i++) vecs.push_back(mk(1, 0, 0, 1, 0));

    @(negedge refclk);
    #1 check("reset_state", outs(), 16'hC000);
    do_reset();
    foreach (vecs[i]) begin
      extlock = vecs[i].ext;
      force_relock = vecs[i].fr;
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    force_relock = 1'b0;

    // Timeout/retry into FAIL with extlock held low.
    do_reset();
    lvl = pll_reset; len = 1; n = 0;
    while (!lock_fail && n < 1000) begin
      step(); n++;
      if (pll_reset == lvl) len++;
      else begin runs.push_back(len); lvl = pll_reset; len = 1; end
    end
    check("fail_reached", lock_fail, 1);
    check("fail_run_count", runs.size(), 6);
    foreach (runs[i]) check($sformatf("fail_run%0d_len", i), runs[i], (i % 2 == 0) ? RST : TO);
    check("fail_retry_cnt", retry_cnt, MAXR);
    check("fail_sys_rst", sys_rst, 1);
    bad = 0;
    repeat (20) begin
      step();
      if (!pll_reset || !lock_fail || !sys_rst) bad++;
    end
    check("fail_hold", bad, 0);

    // Recovery from FAIL.
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check("recover_lock_fail", lock_fail, 0);
    check("recover_retry", retry_cnt, 0);
    check("recover_pll_reset", pll_reset, 1);
    extlock = 1'b1;
    n = 0;
    while (!pll_ready && n < 100) begin step(); n++; end
    check("recover_run", pll_ready, 1);
    check("recover_sys_rst", sys_rst, 0);

    // Glitch during STABLE after one timeout, so retry_cnt must stay at 1.
    do_reset();
    n = 0;
    while (retry_cnt != 4'd1 && n < 200) begin step(); n++; end
    while (pll_reset && n < 220) begin step(); n++; end
    check("glitch_setup", {retry_cnt, pll_reset}, {4'd1, 1'b0});
    extlock = 1'b1;
    fall = -1;
    for (int e = 0; e < 40; e++) begin
      step();
      if (e == 6) extlock = 1'b0;
      if (e == 8) extlock = 1'b1;
      if (e == 9) check("glitch_wait_state", {retry_cnt, pll_reset, sys_rst}, {4'd1, 1'b0, 1'b1});
      if (fall < 0 && !sys_rst) fall = e;
    end
    check("glitch_release_edge", fall, 19);
    check("glitch_run_retry", retry_cnt, 0);

    // Lock loss in RUN, three times.
    for (int i = 0; i < 3; i++) begin
      extlock = 1'b0;
      first = -1;
      for (int e = 0; e < 3; e++) begin
        step();
        if (first < 0 && sys_rst) first = e;
      end
      check($sformatf("loss%0d_sys_rst_edge", i), first, 2);
      len = 1;
      while (len < 20) begin
        step();
        if (!pll_reset) break;
        len++;
      end
      check($sformatf("loss%0d_pulse_len", i), len, RST);
      extlock = 1'b1;
      n = 0;
      while (!pll_ready && n < 100) begin step(); n++; end
      check($sformatf("loss%0d_relock", i), pll_ready, 1);
    end
    check("relock_cnt_3", relock_cnt, 3);

    // Saturation after 260 losses in total.
    tmo = 0;
    for (int i = 0; i < 257; i++) begin
      extlock = 1'b0;
      n = 0;
      while (pll_ready && n < 10) begin step(); n++; end
      extlock = 1'b1;
      while (!pll_ready && n < 100) begin step(); n++; end
      if (n >= 100) tmo++;
    end
    check("relock_loop_timeouts", tmo, 0);
    check("relock_cnt_sat", relock_cnt, 255);

    // Asynchronous reset between edges while in STABLE.
    extlock = 1'b0;
    n = 0;
    while (pll_ready && n < 10) begin step(); n++; end
    extlock = 1'b1;
    while (pll_reset && n < 30) begin step(); n++; end
    repeat (3) step();
    check("stable_before_reset", {pll_reset, sys_rst, pll_ready}, 3'b010);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", outs(), 16'hC000);
    @(negedge refclk);
    reset = 1'b0;
    len = 1;
    while (len < 20) begin
      step();
      if (!pll_reset) break;
      len++;
    end
    check("async_reset_pulse_len", len, RST);

    // Randomized stimulus against the reference model.
    do_reset();
    seg = 0; slvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (seg == 0) begin
        slvl = 1'($urandom_range(0, 1));
        seg = slvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 120));
      end
      extlock = slvl;
      seg--;
      force_relock = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 999) == 0) #2 reset = 1'b1;
      step();
      check($sformatf("rand_c%0d", c), outs(), m_outs());
      reset = 1'b0;
    end
    force_relock = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
